// File: rtl/gnn_pkg.sv
// Shared widths, element types and FSM encoding for the GNN combination stage.
package gnn_pkg;

   localparam int unsigned NODES  = 4;
   localparam int unsigned FEATS  = 4;
   localparam int unsigned FEAT_W = 11;
   localparam int unsigned WGT_W  = 8;
   localparam int unsigned PROD_W = FEAT_W + WGT_W;
   localparam int unsigned ACC_W  = FEAT_W + WGT_W + 2;
   localparam int unsigned K_W    = $clog2(FEATS);

   typedef logic signed [FEAT_W-1:0] feat_t;
   typedef logic signed [WGT_W-1:0]  wgt_t;
   typedef logic signed [PROD_W-1:0] prod_t;
   typedef logic signed [ACC_W-1:0]  acc_t;
   typedef logic        [K_W-1:0]    k_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } comb_state_e;

endpackage : gnn_pkg

// File: rtl/gnn_combine_if.sv
// Job handshake and operand/result bus between the aggregation stage and gnn_combine.
interface gnn_combine_if;
   import gnn_pkg::*;

   logic  in_ready;
   feat_t feat_in  [NODES][FEATS];
   wgt_t  wgt_in   [FEATS][FEATS];
   logic  busy;
   acc_t  out_data [NODES][FEATS];
   logic  ready_out;

   modport master (
      output in_ready, feat_in, wgt_in,
      input  busy, out_data, ready_out
   );

   modport slave (
      input  in_ready, feat_in, wgt_in,
      output busy, out_data, ready_out
   );

endinterface : gnn_combine_if

// File: rtl/gnn_mac_lane.sv
// One node's four output-feature accumulators; each cycle adds x[k] * W[k][j] into acc[j].
module gnn_mac_lane
   import gnn_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  i_clear,
   input  logic  i_en,
   input  feat_t i_x,
   input  wgt_t  i_w   [FEATS],
   output acc_t  o_acc [FEATS]
);

   acc_t  r_acc  [FEATS];
   prod_t w_prod [FEATS];

   // Operands widened to the product width first so the multiply is exact and signed.
   always_comb begin
      for (int j = 0; j < FEATS; j++) begin
         w_prod[j] = prod_t'(i_x) * prod_t'(i_w[j]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         for (int j = 0; j < FEATS; j++) begin
            r_acc[j] <= '0;
         end
      end else if (i_en) begin
         for (int j = 0; j < FEATS; j++) begin
            r_acc[j] <= r_acc[j] + acc_t'(w_prod[j]);
         end
      end
   end

   assign o_acc = r_acc;

endmodule : gnn_mac_lane

// File: rtl/gnn_combine.sv
// Feature transform y = x * W for a 4-node job, accumulated over k in four cycles.
module gnn_combine
   import gnn_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   gnn_combine_if.slave  bus
);

   comb_state_e r_state;
   comb_state_e w_state_nxt;
   logic        w_load;
   logic        w_en;
   k_t          r_k;

   feat_t r_x   [NODES][FEATS];
   wgt_t  r_w   [FEATS][FEATS];
   acc_t  r_out [NODES][FEATS];
   logic  r_busy;
   logic  r_ready;

   feat_t w_xk   [NODES];
   wgt_t  w_wrow [FEATS];
   acc_t  w_acc  [NODES][FEATS];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // A new job may start from DONE, giving back-to-back jobs every five cycles.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_en        = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            if (bus.in_ready) begin
               w_load      = 1'b1;
               w_state_nxt = ACC;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         ACC: begin
            w_en = 1'b1;
            if (r_k == k_t'(FEATS - 1)) begin
               w_state_nxt = DONE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_k <= '0;
      end else if (w_load) begin
         r_k <= '0;
      end else if (w_en) begin
         r_k <= r_k + k_t'(1);
      end
   end

   // Operands are captured once so the upstream bus is free after the start edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int n = 0; n < NODES; n++) begin
            for (int k = 0; k < FEATS; k++) begin
               r_x[n][k] <= '0;
            end
         end
         for (int k = 0; k < FEATS; k++) begin
            for (int j = 0; j < FEATS; j++) begin
               r_w[k][j] <= '0;
            end
         end
      end else if (w_load) begin
         r_x <= bus.feat_in;
         r_w <= bus.wgt_in;
      end
   end

   always_comb begin
      for (int n = 0; n < NODES; n++) begin
         w_xk[n] = r_x[n][r_k];
      end
      for (int j = 0; j < FEATS; j++) begin
         w_wrow[j] = r_w[r_k][j];
      end
   end

   for (genvar n = 0; n < NODES; n++) begin : g_lane
      gnn_mac_lane u_lane (
         .clk     (clk),
         .rst     (rst),
         .i_clear (w_load),
         .i_en    (w_en),
         .i_x     (w_xk[n]),
         .i_w     (w_wrow),
         .o_acc   (w_acc[n])
      );
   end

   // Result is published from the DONE cycle and held until the next job finishes.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy  <= 1'b0;
         r_ready <= 1'b0;
         for (int n = 0; n < NODES; n++) begin
            for (int j = 0; j < FEATS; j++) begin
               r_out[n][j] <= '0;
            end
         end
      end else begin
         r_busy  <= (w_state_nxt == ACC);
         r_ready <= (r_state == DONE);
         if (r_state == DONE) begin
            r_out <= w_acc;
         end
      end
   end

   assign bus.busy      = r_busy;
   assign bus.ready_out = r_ready;
   assign bus.out_data  = r_out;

endmodule : gnn_combine
